// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and the fetch-state enum for the
// small 4-bit CPU. Imported by instruction_fetch and program_counter.
//
// Contents:
//   ADDR_W, DATA_W     program address width and instruction width
//   OP_*               opcode constants (upper nibble of an instruction)
//   fetch_state_t      fetch sequencer states

package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_LDA = 4'h1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        READ  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// program_counter: 4-bit program counter with synchronous load and
// increment, asynchronous active-low reset to zero. Load wins over
// increment; the increment wraps 15 -> 0.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_inc         advance PC by one
//   i_load        load PC from i_load_value
//   i_load_value  load target
//   o_pc          current PC

module program_counter
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_value,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q <= '0;
        end else if (i_load) begin
            pc_q <= i_load_value;
        end else if (i_inc) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch sequencer for the 4-bit CPU. Drives an address,
// strobes a read, latches the returned byte into IR, and presents it to the
// execute stage until that stage signals i_done. A retired HLT opcode parks
// the sequencer in HALT until reset.
//
// Optional feature: define FETCH_SINGLE_STEP_EN to add i_step; a retirement
// that would start the next fetch then also needs i_step high.
//
// Ports:
//   i_clk, i_reset_n   clock and asynchronous active-low reset
//   i_enable           fetch permitted
//   i_bus              program memory read data
//   i_done             execute stage finished the presented instruction
//   i_jump             load PC from i_jump_addr on retirement
//   i_jump_addr        jump target
//   i_step             (FETCH_SINGLE_STEP_EN only) single-step permit
//   o_address          program memory address (always PC)
//   o_read_n           active-low read strobe
//   o_opcode/o_operand IR[7:4] / IR[3:0]
//   o_instr_valid      IR holds an instruction awaiting execution
//   o_pc               current PC
//   o_halted           HLT retired (sticky until reset)

module instruction_fetch
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_done,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              i_step,
`endif
    output logic [ADDR_W-1:0] o_address,
    output logic              o_read_n,
    output logic [3:0]        o_opcode,
    output logic [3:0]        o_operand,
    output logic              o_instr_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              pc_load;
    logic              start_ok;

    program_counter u_pc (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_inc        (pc_inc),
        .i_load       (pc_load),
        .i_load_value (i_jump_addr),
        .o_pc         (pc)
    );

    // Permission to chain straight into the next fetch on retirement.
`ifdef FETCH_SINGLE_STEP_EN
    assign start_ok = i_step;
`else
    assign start_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ir_q <= '0;
        end else if (state_q == READ) begin
            ir_q <= i_bus;
        end
    end

    // A retirement that is held back (single-step without i_step) does not
    // take the jump either, so a later retirement applies it exactly once.
    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = READ;
            end
            READ: begin
                pc_inc  = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                if (i_done) begin
                    if (ir_q[7:4] == OP_HLT) begin
                        state_d = HALT;
                    end else if (!i_enable) begin
                        pc_load = i_jump;
                        state_d = IDLE;
                    end else if (start_ok) begin
                        pc_load = i_jump;
                        state_d = ADDR;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from state, PC and IR only; nothing passes through from inputs.
    assign o_address     = pc;
    assign o_pc          = pc;
    assign o_read_n      = (state_q != READ);
    assign o_instr_valid = (state_q == VALID);
    assign o_halted      = (state_q == HALT);
    assign o_opcode      = ir_q[7:4];
    assign o_operand     = ir_q[3:0];

endmodule
